// File: rtl/div_signed_iter_if.sv
// Operand/result bundle for div_signed_iter: valid/ready operand side plus the
// registered result strobe, quotient, remainder and exception flags.
interface div_signed_iter_if #(
  parameter int WIDTH = 16
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] A;
  logic signed [WIDTH-1:0] B;
  logic                    out_valid;
  logic signed [WIDTH-1:0] Q;
  logic signed [WIDTH-1:0] R;
  logic                    div_zero;
  logic                    ovf;

  modport master (
    output in_valid, A, B,
    input  in_ready, out_valid, Q, R, div_zero, ovf
  );

  modport slave (
    input  in_valid, A, B,
    output in_ready, out_valid, Q, R, div_zero, ovf
  );
endinterface

// File: rtl/div_signed_iter.sv
// Iterative radix-2 restoring signed divider (truncating; Q*B + R = A).
// Define DIV_SIGNED_ROUND_EN to round the quotient to nearest, ties away from zero.
module div_signed_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic               clk,
  input logic               rst_n,
  input logic               CE,
  input logic               SCLR,
  div_signed_iter_if.slave  bus
);

  localparam logic [1:0]       S_IDLE = 2'd0;
  localparam logic [1:0]       S_CALC = 2'd1;
  localparam logic [1:0]       S_SIGN = 2'd2;
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAXP   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH-1);

  function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] m);
    return neg ? (~m + ONE) : m;
  endfunction

  // Magnitude of -2^(W-1) wraps to itself, which is correct read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return apply_sign(x[WIDTH-1], x);
  endfunction

`ifdef DIV_SIGNED_ROUND_EN
  function automatic logic round_up(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] d);
    return {r, 1'b0} >= {1'b0, d};
  endfunction
`endif

  logic [1:0]              state_q,  state_d;
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  logic [WIDTH-1:0]        wq_q,     wq_d;
  logic [WIDTH-1:0]        rem_q,    rem_d;
  logic [WIDTH-1:0]        dvs_q,    dvs_d;
  logic [WIDTH-1:0]        a_q,      a_d;
  logic                    sgn_a_q,  sgn_a_d;
  logic                    sgn_q_q,  sgn_q_d;
  logic                    dz_q,     dz_d;
  logic                    ov_q,     ov_d;
  logic signed [WIDTH-1:0] q_q,      q_d;
  logic signed [WIDTH-1:0] r_q,      r_d;
  logic                    dzo_q,    dzo_d;
  logic                    ovo_q,    ovo_d;
  logic                    vld_q,    vld_d;

  logic [WIDTH:0]          rem_sh;
  logic [WIDTH:0]          diff;
  logic                    q_bit;
  logic [WIDTH-1:0]        mq, mr;
  logic                    r_neg;
  logic [WIDTH-1:0]        q_res, r_res;

  // Restoring step: wq_q shifts the dividend out at the top while quotient bits enter at the bottom.
  always_comb begin
    rem_sh = {rem_q, wq_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    q_bit  = ~diff[WIDTH];
  end

  always_comb begin
    mq    = wq_q;
    mr    = rem_q;
    r_neg = sgn_a_q;
`ifdef DIV_SIGNED_ROUND_EN
    if (round_up(mr, dvs_q)) begin
      mq    = mq + ONE;
      mr    = dvs_q - mr;
      r_neg = ~sgn_a_q;
    end
`endif
    q_res = apply_sign(sgn_q_q, mq);
    r_res = apply_sign(r_neg, mr);
    if (dz_q) begin
      q_res = sgn_a_q ? MINN : MAXP;
      r_res = a_q;
    end else if (ov_q) begin
      q_res = MAXP;
      r_res = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wq_d    = wq_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    sgn_a_d = sgn_a_q;
    sgn_q_d = sgn_q_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    q_d     = q_q;
    r_d     = r_q;
    dzo_d   = dzo_q;
    ovo_d   = ovo_q;
    vld_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          wq_d    = magnitude(bus.A);
          dvs_d   = magnitude(bus.B);
          a_d     = bus.A;
          sgn_a_d = bus.A[WIDTH-1];
          sgn_q_d = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
          dz_d    = (bus.B == '0);
          ov_d    = (bus.A == MINN) && (bus.B == '1);
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        wq_d  = {wq_q[WIDTH-2:0], q_bit};
        rem_d = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = S_SIGN;
      end
      S_SIGN: begin
        q_d     = q_res;
        r_d     = r_res;
        dzo_d   = dz_q;
        ovo_d   = ov_q;
        vld_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (SCLR) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      wq_d    = '0;
      rem_d   = '0;
      dvs_d   = '0;
      a_d     = '0;
      sgn_a_d = 1'b0;
      sgn_q_d = 1'b0;
      dz_d    = 1'b0;
      ov_d    = 1'b0;
      q_d     = '0;
      r_d     = '0;
      dzo_d   = 1'b0;
      ovo_d   = 1'b0;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wq_q    <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      sgn_a_q <= 1'b0;
      sgn_q_q <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dzo_q   <= 1'b0;
      ovo_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else if (CE) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wq_q    <= wq_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      sgn_a_q <= sgn_a_d;
      sgn_q_q <= sgn_q_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dzo_q   <= dzo_d;
      ovo_q   <= ovo_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = vld_q;
  assign bus.Q         = q_q;
  assign bus.R         = r_q;
  assign bus.div_zero  = dzo_q;
  assign bus.ovf       = ovo_q;

endmodule

// File: tb/tb_div_signed_iter.sv
// Directed bench for div_signed_iter (WIDTH=16): quotient/remainder, flags,
// latency, CE stall, back-to-back, reset and SCLR abort.
module tb_div_signed_iter;
  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic CE    = 1'b0;
  logic SCLR  = 1'b0;

  div_signed_iter_if #(.WIDTH(W)) bus ();

  div_signed_iter #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .CE    (CE),
    .SCLR  (SCLR),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input string tag, input int a, input int b, input int eq, input int er,
                         input int edz, input int eov, input bit hold_en, input int hold_q);
    int n;
    int bad;
    n   = 0;
    bad = 0;
    CE  = 1'b1;
    bus.A = a[W-1:0];
    bus.B = b[W-1:0];
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk({tag, ".busy"}, bus.in_ready, 0);
    while (!bus.out_valid && n < 40) begin
      if (hold_en && $signed(bus.Q) != hold_q) bad++;
      tick();
      n++;
    end
    chk({tag, ".lat"}, n, 17);
    chk({tag, ".Q"}, bus.Q, eq);
    chk({tag, ".R"}, bus.R, er);
    chk({tag, ".dz"}, bus.div_zero, edz);
    chk({tag, ".ovf"}, bus.ovf, eov);
    if (hold_en) chk({tag, ".hold"}, bad, 0);
  endtask

  task automatic count_strobes(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.out_valid) cnt++;
    end
    chk(tag, cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;

    tick();
    tick();
    chk("rst.ready", bus.in_ready, 1);
    chk("rst.vld", bus.out_valid, 0);
    chk("rst.Q", bus.Q, 0);
    chk("rst.R", bus.R, 0);
    chk("rst.dz", bus.div_zero, 0);
    chk("rst.ovf", bus.ovf, 0);
    rst_n = 1'b1;
    CE = 1'b1;
    tick();

    run_div("d1", 100, 7, 14, 2, 0, 0, 0, 0);
    run_div("b2b", -100, 7, -14, -2, 0, 0, 1, 14);
`ifdef DIV_SIGNED_ROUND_EN
    run_div("d3", 100, -8, -13, -4, 0, 0, 0, 0);
    run_div("d8", 7, 2, 4, -1, 0, 0, 0, 0);
    run_div("d9", -7, 2, -4, 1, 0, 0, 0, 0);
    run_div("d10", 32767, -32768, -1, -1, 0, 0, 0, 0);
`else
    run_div("d3", 100, -8, -12, 4, 0, 0, 0, 0);
    run_div("d8", 7, 2, 3, 1, 0, 0, 0, 0);
    run_div("d9", -7, 2, -3, -1, 0, 0, 0, 0);
    run_div("d10", 32767, -32768, 0, 32767, 0, 0, 0, 0);
`endif
    run_div("dz+", 5, 0, 32767, 5, 1, 0, 0, 0);
    run_div("dz-", -5, 0, -32768, -5, 1, 0, 0, 0);
    run_div("ovf", -32768, -1, 32767, 0, 0, 1, 0, 0);
    run_div("min1", -32768, 1, -32768, 0, 0, 0, 0, 0);
    tick();

    // CE stall of 5 cycles starting at the 8th edge after accept, with stray in_valid pulses.
    bus.A = 16'sd1000;
    bus.B = 16'sd3;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (n < 40) begin
      CE = !(n >= 7 && n <= 11);
      bus.in_valid = (n == 2 || n == 8);
      bus.A = 16'sd5;
      bus.B = 16'sd1;
      tick();
      n++;
      if (bus.out_valid) break;
    end
    CE = 1'b1;
    bus.in_valid = 1'b0;
    chk("ce.lat", n, 22);
    chk("ce.Q", bus.Q, 333);
    chk("ce.R", bus.R, 1);
    CE = 1'b0;
    tick();
    tick();
    chk("ce.stretch", bus.out_valid, 1);
    CE = 1'b1;
    count_strobes("ce.single", 25);
    chk("ce.Qhold", bus.Q, 333);

    // Asynchronous reset mid-calculation.
    bus.A = 16'sd1000;
    bus.B = 16'sd3;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    chk("arst.ready", bus.in_ready, 1);
    chk("arst.Q", bus.Q, 0);
    chk("arst.R", bus.R, 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_strobes("arst.nostrobe", 25);

    // Synchronous clear mid-calculation.
    run_div("pre", -1000, 3, -333, -1, 0, 0, 0, 0);
    bus.A = 16'sd100;
    bus.B = 16'sd7;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    SCLR = 1'b1;
    tick();
    SCLR = 1'b0;
    chk("sclr.ready", bus.in_ready, 1);
    chk("sclr.Q", bus.Q, 0);
    chk("sclr.R", bus.R, 0);
    count_strobes("sclr.nostrobe", 25);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
